axi2per_resp_queue: RTL and testbench

// Response path of the AXI-to-peripheral bridge with multiple outstanding transactions.
// - Records per-request metadata (id, kind, lane, user) in an in-order completion queue.
// - Captures unbackpressured peripheral responses into that queue.
// - Returns them as single-beat AXI R or B responses, in request order.
// - Replaces the single-transaction response channel: adds depth, width-generic lane steering and SLVERR reporting.

---
 rtl/axi2per_resp_queue_if.sv | 60 ++++++
 rtl/axi2per_resp_queue.sv | 140 ++++++++++++++
 tb/tb_axi2per_resp_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/axi2per_resp_queue_if.sv
// Request, peripheral-response and AXI R/B channel bundle for the response queue.
// The queue is the AXI slave: it drives the R/B channels and trans_ready_o.
interface axi2per_resp_queue_if #(
    parameter int PER_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 6
);
    logic                      trans_req_i;
    logic                      trans_we_i;
    logic [AXI_ID_WIDTH-1:0]   trans_id_i;
    logic [AXI_ADDR_WIDTH-1:0] trans_add_i;
    logic [AXI_USER_WIDTH-1:0] trans_user_i;
    logic                      trans_ready_o;

    logic                      per_master_r_valid_i;
    logic                      per_master_r_opc_i;
    logic [PER_DATA_WIDTH-1:0] per_master_r_rdata_i;

    logic                      axi_slave_r_valid_o;
    logic                      axi_slave_r_ready_i;
    logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o;
    logic [1:0]                axi_slave_r_resp_o;
    logic                      axi_slave_r_last_o;
    logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o;
    logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o;

    logic                      axi_slave_b_valid_o;
    logic                      axi_slave_b_ready_i;
    logic [1:0]                axi_slave_b_resp_o;
    logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o;
    logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o;

    modport slave (
        input  trans_req_i, trans_we_i, trans_id_i, trans_add_i, trans_user_i,
        output trans_ready_o,
        input  per_master_r_valid_i, per_master_r_opc_i, per_master_r_rdata_i,
        output axi_slave_r_valid_o,
        input  axi_slave_r_ready_i,
        output axi_slave_r_data_o, axi_slave_r_resp_o, axi_slave_r_last_o,
        output axi_slave_r_id_o, axi_slave_r_user_o,
        output axi_slave_b_valid_o,
        input  axi_slave_b_ready_i,
        output axi_slave_b_resp_o, axi_slave_b_id_o, axi_slave_b_user_o
    );

    modport master (
        output trans_req_i, trans_we_i, trans_id_i, trans_add_i, trans_user_i,
        input  trans_ready_o,
        output per_master_r_valid_i, per_master_r_opc_i, per_master_r_rdata_i,
        input  axi_slave_r_valid_o,
        output axi_slave_r_ready_i,
        input  axi_slave_r_data_o, axi_slave_r_resp_o, axi_slave_r_last_o,
        input  axi_slave_r_id_o, axi_slave_r_user_o,
        input  axi_slave_b_valid_o,
        output axi_slave_b_ready_i,
        input  axi_slave_b_resp_o, axi_slave_b_id_o, axi_slave_b_user_o
    );
endinterface

// File: rtl/axi2per_resp_queue.sv
// In-order completion queue for the AXI-to-peripheral bridge: records request metadata,
// captures unbackpressured peripheral responses and returns them as single-beat R/B responses.
module axi2per_resp_queue #(
    parameter int PER_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ID_WIDTH    = 3,
    parameter int AXI_USER_WIDTH  = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    axi2per_resp_queue_if.slave                bus,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_unexpected_o
);
    localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W    = PTR_W + 1;
    localparam int RATIO    = AXI_DATA_WIDTH / PER_DATA_WIDTH;
    localparam int LANE_W   = $clog2(RATIO);
    localparam int LANE_SW  = (LANE_W > 0) ? LANE_W : 1;
    localparam int LANE_LSB = $clog2(PER_DATA_WIDTH / 8);

    // Pointers carry an extra wrap bit so "all entries awaiting a response"
    // (wr == rsp index, wrap differs) is distinguishable from "none awaiting".
    logic [CNT_W-1:0] r_wr_ptr, r_rsp_ptr, r_rd_ptr;
    logic             r_err;

    logic                      r_we   [MAX_OUTSTANDING];
    logic [AXI_ID_WIDTH-1:0]   r_id   [MAX_OUTSTANDING];
    logic [AXI_USER_WIDTH-1:0] r_user [MAX_OUTSTANDING];
    logic [LANE_SW-1:0]        r_lane [MAX_OUTSTANDING];
    logic                      r_done [MAX_OUTSTANDING];
    logic                      r_opc  [MAX_OUTSTANDING];
    logic [PER_DATA_WIDTH-1:0] r_data [MAX_OUTSTANDING];

    logic [PTR_W-1:0]          w_wr_idx, w_rsp_idx, w_rd_idx;
    logic [CNT_W-1:0]          w_count;
    logic                      w_ready, w_push, w_awaiting, w_capture, w_pop;
    logic                      w_r_valid, w_b_valid;
    logic [LANE_SW-1:0]        w_push_lane;
    logic [AXI_DATA_WIDTH-1:0] w_r_data;
    logic                      w_unused;

    assign w_wr_idx   = r_wr_ptr[PTR_W-1:0];
    assign w_rsp_idx  = r_rsp_ptr[PTR_W-1:0];
    assign w_rd_idx   = r_rd_ptr[PTR_W-1:0];
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_ready    = (w_count != CNT_W'(MAX_OUTSTANDING));
    assign w_push     = bus.trans_req_i & w_ready;
    assign w_awaiting = (r_wr_ptr != r_rsp_ptr);
    assign w_capture  = bus.per_master_r_valid_i & w_awaiting;

    assign w_r_valid = r_done[w_rd_idx] & r_we[w_rd_idx];
    assign w_b_valid = r_done[w_rd_idx] & ~r_we[w_rd_idx];
    assign w_pop     = (w_r_valid & bus.axi_slave_r_ready_i) | (w_b_valid & bus.axi_slave_b_ready_i);

    generate
        if (LANE_W > 0) begin : g_lane
            assign w_push_lane = bus.trans_add_i[LANE_LSB +: LANE_SW];
        end else begin : g_no_lane
            assign w_push_lane = '0;
        end
    endgenerate

    // Only the lane bits of the address are stored; the rest is intentionally dropped.
    assign w_unused = ^bus.trans_add_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr  <= '0;
            r_rsp_ptr <= '0;
            r_rd_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            if (w_capture)
                r_rsp_ptr <= r_rsp_ptr + CNT_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            if (bus.per_master_r_valid_i && !w_awaiting)
                r_err <= 1'b1;
        end
    end

    // Push, capture and pop always target distinct entries, so each slot sees at most one.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_we[gi]   <= 1'b0;
                    r_id[gi]   <= '0;
                    r_user[gi] <= '0;
                    r_lane[gi] <= '0;
                    r_done[gi] <= 1'b0;
                    r_opc[gi]  <= 1'b0;
                    r_data[gi] <= '0;
                end else begin
                    if (w_push && (w_wr_idx == PTR_W'(gi))) begin
                        r_we[gi]   <= bus.trans_we_i;
                        r_id[gi]   <= bus.trans_id_i;
                        r_user[gi] <= bus.trans_user_i;
                        r_lane[gi] <= w_push_lane;
                        r_done[gi] <= 1'b0;
                    end
                    if (w_capture && (w_rsp_idx == PTR_W'(gi))) begin
                        r_data[gi] <= bus.per_master_r_rdata_i;
                        r_opc[gi]  <= bus.per_master_r_opc_i;
                        r_done[gi] <= 1'b1;
                    end
                    if (w_pop && (w_rd_idx == PTR_W'(gi)))
                        r_done[gi] <= 1'b0;
                end
            end
        end

        for (genvar gi = 0; gi < RATIO; gi++) begin : g_steer
            assign w_r_data[gi*PER_DATA_WIDTH +: PER_DATA_WIDTH] =
                (w_r_valid && (r_lane[w_rd_idx] == LANE_SW'(gi))) ? r_data[w_rd_idx] : '0;
        end
    endgenerate

    assign bus.trans_ready_o = w_ready;

    assign bus.axi_slave_r_valid_o = w_r_valid;
    assign bus.axi_slave_r_data_o  = w_r_data;
    assign bus.axi_slave_r_resp_o  = (w_r_valid && r_opc[w_rd_idx]) ? 2'b10 : 2'b00;
    assign bus.axi_slave_r_last_o  = w_r_valid;
    assign bus.axi_slave_r_id_o    = w_r_valid ? r_id[w_rd_idx] : '0;
    assign bus.axi_slave_r_user_o  = w_r_valid ? r_user[w_rd_idx] : '0;

    assign bus.axi_slave_b_valid_o = w_b_valid;
    assign bus.axi_slave_b_resp_o  = (w_b_valid && r_opc[w_rd_idx]) ? 2'b10 : 2'b00;
    assign bus.axi_slave_b_id_o    = w_b_valid ? r_id[w_rd_idx] : '0;
    assign bus.axi_slave_b_user_o  = w_b_valid ? r_user[w_rd_idx] : '0;

    assign outstanding_o    = w_count;
    assign err_unexpected_o = r_err;
endmodule

// File: tb/tb_axi2per_resp_queue.sv
// Directed bench for axi2per_resp_queue: R/B ordering, lane steering, SLVERR, full queue,
// unexpected responses and asynchronous reset.
module tb_axi2per_resp_queue;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] outstanding_o;
    logic       err_unexpected_o;
    int         n_assert = 0;
    int         n_fail   = 0;

    axi2per_resp_queue_if #(
        .PER_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(3), .AXI_USER_WIDTH(6)
    ) bus ();

    axi2per_resp_queue #(
        .PER_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
        .AXI_ID_WIDTH(3), .AXI_USER_WIDTH(6), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .outstanding_o    (outstanding_o),
        .err_unexpected_o (err_unexpected_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic we, input logic [2:0] id, input logic [31:0] add, input logic [5:0] user);
        bus.trans_req_i  = 1'b1;
        bus.trans_we_i   = we;
        bus.trans_id_i   = id;
        bus.trans_add_i  = add;
        bus.trans_user_i = user;
        tick();
        bus.trans_req_i  = 1'b0;
        $display("push we=%0d id=%0d add=%0h outstanding=%0d", we, id, add, outstanding_o);
    endtask

    initial begin
        bus.trans_req_i = 0; bus.trans_we_i = 0; bus.trans_id_i = 0; bus.trans_add_i = 0;
        bus.trans_user_i = 0; bus.per_master_r_valid_i = 0; bus.per_master_r_opc_i = 0;
        bus.per_master_r_rdata_i = 0; bus.axi_slave_r_ready_i = 0; bus.axi_slave_b_ready_i = 0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_ready", 64'(bus.trans_ready_o), 64'd1);
        chk("rst_r_valid", 64'(bus.axi_slave_r_valid_o), 64'd0);
        chk("rst_b_valid", 64'(bus.axi_slave_b_valid_o), 64'd0);
        chk("rst_err", 64'(err_unexpected_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // 1: single read, upper lane
        push(1'b1, 3'd5, 32'h4, 6'h11);
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        chk("t1_no_valid_yet", 64'(bus.axi_slave_r_valid_o), 64'd0);
        bus.per_master_r_valid_i = 1; bus.per_master_r_rdata_i = 32'hDEADBEEF; bus.per_master_r_opc_i = 0;
        tick();
        bus.per_master_r_valid_i = 0;
        $display("t1 R valid=%0d data=%h id=%0d", bus.axi_slave_r_valid_o, bus.axi_slave_r_data_o, bus.axi_slave_r_id_o);
        chk("t1_r_valid", 64'(bus.axi_slave_r_valid_o), 64'd1);
        chk("t1_r_data", bus.axi_slave_r_data_o, 64'hDEADBEEF_00000000);
        chk("t1_r_resp", 64'(bus.axi_slave_r_resp_o), 64'd0);
        chk("t1_r_last", 64'(bus.axi_slave_r_last_o), 64'd1);
        chk("t1_r_id", 64'(bus.axi_slave_r_id_o), 64'd5);
        chk("t1_r_user", 64'(bus.axi_slave_r_user_o), 64'h11);
        chk("t1_b_valid", 64'(bus.axi_slave_b_valid_o), 64'd0);
        bus.axi_slave_r_ready_i = 1;
        tick();
        bus.axi_slave_r_ready_i = 0;
        chk("t1_popped", 64'(bus.axi_slave_r_valid_o), 64'd0);
        chk("t1_empty", 64'(outstanding_o), 64'd0);

        // 2: write with peripheral error, B held under backpressure
        push(1'b0, 3'd2, 32'h0, 6'h03);
        bus.per_master_r_valid_i = 1; bus.per_master_r_opc_i = 1; bus.per_master_r_rdata_i = 32'h12345678;
        tick();
        bus.per_master_r_valid_i = 0; bus.per_master_r_opc_i = 0;
        for (int i = 0; i < 3; i++) begin
            $display("t2 cycle %0d B valid=%0d resp=%0d id=%0d", i, bus.axi_slave_b_valid_o, bus.axi_slave_b_resp_o, bus.axi_slave_b_id_o);
            chk("t2_b_valid_held", 64'(bus.axi_slave_b_valid_o), 64'd1);
            chk("t2_b_resp", 64'(bus.axi_slave_b_resp_o), 64'd2);
            chk("t2_b_id", 64'(bus.axi_slave_b_id_o), 64'd2);
            chk("t2_r_valid", 64'(bus.axi_slave_r_valid_o), 64'd0);
            tick();
        end
        chk("t2_b_user", 64'(bus.axi_slave_b_user_o), 64'h03);
        bus.axi_slave_b_ready_i = 1;
        chk("t2_valid_before_pop", 64'(bus.axi_slave_b_valid_o), 64'd1);
        tick();
        bus.axi_slave_b_ready_i = 0;
        chk("t2_popped", 64'(bus.axi_slave_b_valid_o), 64'd0);
        chk("t2_empty", 64'(outstanding_o), 64'd0);

        // 3: fill the queue, drop a request while full, then drain back-to-back
        for (int i = 0; i < 4; i++) push(1'b1, 3'(i), 32'(i * 4), 6'(i));
        chk("t3_ready_full", 64'(bus.trans_ready_o), 64'd0);
        chk("t3_outstanding_full", 64'(outstanding_o), 64'd4);
        push(1'b1, 3'd7, 32'h0, 6'h0);
        chk("t3_drop_when_full", 64'(outstanding_o), 64'd4);
        bus.per_master_r_valid_i = 1; bus.axi_slave_r_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] exp_data;
            bus.per_master_r_rdata_i = 32'h1000 + 32'(i);
            tick();
            exp_data = (i % 2 == 1) ? {32'h1000 + 32'(i), 32'h0} : {32'h0, 32'h1000 + 32'(i)};
            $display("t3 R id=%0d data=%h outstanding=%0d ready=%0d", bus.axi_slave_r_id_o, bus.axi_slave_r_data_o, outstanding_o, bus.trans_ready_o);
            chk("t3_r_valid", 64'(bus.axi_slave_r_valid_o), 64'd1);
            chk("t3_r_id", 64'(bus.axi_slave_r_id_o), 64'(i));
            chk("t3_r_data", bus.axi_slave_r_data_o, exp_data);
            chk("t3_outstanding", 64'(outstanding_o), 64'(4 - i));
            chk("t3_ready", 64'(bus.trans_ready_o), (i == 0) ? 64'd0 : 64'd1);
        end
        bus.per_master_r_valid_i = 0;
        tick();
        bus.axi_slave_r_ready_i = 0;
        chk("t3_drained", 64'(bus.axi_slave_r_valid_o), 64'd0);
        chk("t3_empty", 64'(outstanding_o), 64'd0);

        // 4: interleaved write/read/write come back strictly in order
        push(1'b0, 3'd1, 32'h0, 6'h21);
        push(1'b1, 3'd6, 32'h0, 6'h22);
        push(1'b0, 3'd3, 32'h0, 6'h23);
        bus.per_master_r_valid_i = 1; bus.per_master_r_opc_i = 0; bus.per_master_r_rdata_i = 32'hA5A5A5A5;
        bus.axi_slave_r_ready_i = 1; bus.axi_slave_b_ready_i = 1;
        tick();
        $display("t4 step0 B=%0d id=%0d R=%0d", bus.axi_slave_b_valid_o, bus.axi_slave_b_id_o, bus.axi_slave_r_valid_o);
        chk("t4_b1_valid", 64'(bus.axi_slave_b_valid_o), 64'd1);
        chk("t4_b1_id", 64'(bus.axi_slave_b_id_o), 64'd1);
        chk("t4_b1_no_r", 64'(bus.axi_slave_r_valid_o), 64'd0);
        tick();
        $display("t4 step1 R=%0d id=%0d B=%0d", bus.axi_slave_r_valid_o, bus.axi_slave_r_id_o, bus.axi_slave_b_valid_o);
        chk("t4_r6_valid", 64'(bus.axi_slave_r_valid_o), 64'd1);
        chk("t4_r6_id", 64'(bus.axi_slave_r_id_o), 64'd6);
        chk("t4_r6_data", bus.axi_slave_r_data_o, 64'h00000000_A5A5A5A5);
        chk("t4_r6_no_b", 64'(bus.axi_slave_b_valid_o), 64'd0);
        tick();
        bus.per_master_r_valid_i = 0;
        $display("t4 step2 B=%0d id=%0d R=%0d", bus.axi_slave_b_valid_o, bus.axi_slave_b_id_o, bus.axi_slave_r_valid_o);
        chk("t4_b3_valid", 64'(bus.axi_slave_b_valid_o), 64'd1);
        chk("t4_b3_id", 64'(bus.axi_slave_b_id_o), 64'd3);
        chk("t4_b3_no_r", 64'(bus.axi_slave_r_valid_o), 64'd0);
        tick();
        bus.axi_slave_r_ready_i = 0; bus.axi_slave_b_ready_i = 0;
        chk("t4_empty", 64'(outstanding_o), 64'd0);

        // 5: unexpected response
        chk("t5_err_before", 64'(err_unexpected_o), 64'd0);
        bus.per_master_r_valid_i = 1; bus.per_master_r_rdata_i = 32'hFFFFFFFF;
        tick();
        bus.per_master_r_valid_i = 0;
        $display("t5 err=%0d R=%0d B=%0d", err_unexpected_o, bus.axi_slave_r_valid_o, bus.axi_slave_b_valid_o);
        chk("t5_err", 64'(err_unexpected_o), 64'd1);
        chk("t5_no_r", 64'(bus.axi_slave_r_valid_o), 64'd0);
        chk("t5_no_b", 64'(bus.axi_slave_b_valid_o), 64'd0);
        chk("t5_outstanding", 64'(outstanding_o), 64'd0);
        tick();
        chk("t5_err_sticky", 64'(err_unexpected_o), 64'd1);

        // 6: asynchronous reset with pending entries
        push(1'b1, 3'd4, 32'h0, 6'h0);
        push(1'b1, 3'd5, 32'h0, 6'h0);
        bus.per_master_r_valid_i = 1; bus.per_master_r_rdata_i = 32'h55;
        tick();
        bus.per_master_r_valid_i = 0;
        chk("t6_r_valid_pre", 64'(bus.axi_slave_r_valid_o), 64'd1);
        chk("t6_outstanding_pre", 64'(outstanding_o), 64'd2);
        rst_ni = 1'b0;
        #1;
        $display("t6 reset R=%0d outstanding=%0d err=%0d", bus.axi_slave_r_valid_o, outstanding_o, err_unexpected_o);
        chk("t6_r_valid_drop", 64'(bus.axi_slave_r_valid_o), 64'd0);
        chk("t6_err_cleared", 64'(err_unexpected_o), 64'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_outstanding_post", 64'(outstanding_o), 64'd0);
        chk("t6_ready_post", 64'(bus.trans_ready_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
